reg_rename_file: RTL and testbench
==================================

Name: reg_rename_file

Overview:
- Architectural register file with per-register rename tags, sitting directly downstream of the reorder buffer.
- Consumes the ROB commit stream (rd, value, reorder tag) and the ROB flush pulse.
- Serves the decoder's combinational operand queries: value when the register is clean, or the reorder tag of the in-flight producer when it is busy.
- Records the decoder's destination renames at issue.

Parameters:
- REG_NUM, 32, number of architectural registers; x0 is hardwired to zero.
- REG_W, 5, register index width.
- DATA_W, 32, register data width.
- ROB_W, 4, reorder tag width; tag 0 is reserved as "no producer", and valid tags are 1..15.

Ports:
- in_clk  input  1  clock; all state updates on the rising edge.
- in_rst  input  1  synchronous active-high reset.
- in_rdy  input  1  global ready; when low, all state holds.
- in_flush_enable  input  1  ROB misprediction flush pulse.
- in_decoder_rs  input  REG_W  source register 1 index.
- in_decoder_rt  input  REG_W  source register 2 index.
- out_decoder_rs_busy  output  1  rs awaits an in-flight producer.
- out_decoder_rs_reorder  output  ROB_W  producer tag for rs; 0 when not busy.
- out_decoder_rs_value  output  DATA_W  rs value; valid when not busy.
- out_decoder_rt_busy  output  1  same as rs_busy, for rt.
- out_decoder_rt_reorder  output  ROB_W  same as rs_reorder, for rt.
- out_decoder_rt_value  output  DATA_W  same as rs_value, for rt.
- in_decoder_rename_enable  input  1  issue of an instruction writing rd.
- in_decoder_rename_rd  input  REG_W  destination register being renamed.
- in_decoder_rename_reorder  input  ROB_W  ROB entry allocated to that instruction.
- in_rob_commit_enable  input  1  ROB commits a register write.
- in_rob_commit_rd  input  REG_W  committed destination.
- in_rob_commit_value  input  DATA_W  committed value.
- in_rob_commit_reorder  input  ROB_W  ROB entry being committed.

Behaviour:
- State per register: value[DATA_W], busy[1], tag[ROB_W].
- Reset (in_rst high at the edge), for all registers: value=0, busy=0, tag=0.
  - Query outputs are combinational, so immediately after reset any query returns busy=0, reorder=0, value=0.
- Query path (combinational, zero latency), for each of rs and rt:
  - Index 0: busy=0, reorder=0, value=0 unconditionally.
  - Otherwise, if busy[idx]=1 and in_rob_commit_enable=1, in_rob_commit_rd==idx and in_rob_commit_reorder==tag[idx]: forward the commit, i.e. busy=0, reorder=0, value=in_rob_commit_value.
  - Otherwise: busy=busy[idx], reorder = busy ? tag[idx] : 0, value=value[idx].
  - Queries reflect pre-edge state. A rename presented in the same cycle never affects that cycle's query, because the query belongs to the instruction being renamed.
- Sequential update on the edge, only when in_rdy=1; with in_rdy=0 nothing changes.
  - Commit, when in_rob_commit_enable=1 and rd!=0:
    - value[rd] <= commit_value, always, including on flush cycles.
    - busy[rd] <= 0 and tag[rd] <= 0 only if tag[rd]==commit_reorder and no same-rd rename wins (see priority below). A stale commit (tag mismatch) writes the value and leaves busy/tag untouched.
  - Rename, when in_decoder_rename_enable=1, rd!=0 and in_flush_enable=0: busy[rd] <= 1, tag[rd] <= rename_reorder.
  - Priority for the same rd in one cycle: rename beats commit's busy clear; the value write still happens.
  - Flush, when in_flush_enable=1: every busy <= 0 and every tag <= 0; any rename in that cycle is ignored.
    - A commit in the flush cycle still writes its value. The ROB commits JALR together with the flush, so this case occurs in normal operation.
- Writes or renames to x0 are discarded; value[0] stays 0.
- Tag width ROB_W and tag 0 are never allocated by the ROB; the block does not check this.
- Commit and rename to different registers in the same cycle are independent.
- Reset in the middle of operation has priority over in_rdy, flush, commit and rename.

Test Plan:
- Reset, then query rs=5, rt=0 -> busy=0/0, reorder=0/0, value=0/0.
- Rename x5 tag 3; next cycle query rs=5 -> busy=1, reorder=3. Commit x5 tag 3 value 0x1234 in that same cycle -> forwarded busy=0, value=0x1234. Next cycle -> busy=0, value=0x1234 from state.
- Rename x7 tag 2, then rename x7 tag 6; commit x7 tag 2 value 0xAA -> value[7]=0xAA, busy=1, tag=6. Commit tag 6 value 0xBB -> busy=0, value=0xBB.
- In the same cycle, commit x9 tag 4 value 0x55 and rename x9 tag 8 (tag[9] was 4) -> value=0x55, busy=1, tag=8.
- Rename x1 tag 1, x2 tag 2, x3 tag 3; then flush together with commit x1 tag 1 value 0x80000004 and rename x4 tag 5 -> all busy=0, value[1]=0x80000004, x4 not busy.
- With in_rdy=0, rename x10 and commit x11 -> no state change. Rename and commit to x0 -> query x0 returns 0 with busy=0.

Source files
------------

// File: rtl/reg_rename_file.sv
// reg_rename_file: architectural register file with per-register rename tags.
// Sits after the reorder buffer; x0 is hardwired to zero.
//
// Ports:
//   in_clk, in_rst            clock, synchronous active-high reset
//   in_rdy                    global ready; state holds when low
//   in_flush_enable           misprediction flush, clears all busy/tags
//   in_decoder_rs/rt          operand query indices (combinational)
//   out_decoder_rs/rt_*       busy flag, producer tag, value per operand
//   in_decoder_rename_*       destination rename at issue (rd, tag)
//   in_rob_commit_*           ROB commit stream (rd, value, tag)
module reg_rename_file #(
    parameter int REG_NUM = 32,
    parameter int REG_W   = 5,
    parameter int DATA_W  = 32,
    parameter int ROB_W   = 4
) (
    input  logic              in_clk,
    input  logic              in_rst,
    input  logic              in_rdy,
    input  logic              in_flush_enable,
    input  logic [REG_W-1:0]  in_decoder_rs,
    input  logic [REG_W-1:0]  in_decoder_rt,
    output logic              out_decoder_rs_busy,
    output logic [ROB_W-1:0]  out_decoder_rs_reorder,
    output logic [DATA_W-1:0] out_decoder_rs_value,
    output logic              out_decoder_rt_busy,
    output logic [ROB_W-1:0]  out_decoder_rt_reorder,
    output logic [DATA_W-1:0] out_decoder_rt_value,
    input  logic              in_decoder_rename_enable,
    input  logic [REG_W-1:0]  in_decoder_rename_rd,
    input  logic [ROB_W-1:0]  in_decoder_rename_reorder,
    input  logic              in_rob_commit_enable,
    input  logic [REG_W-1:0]  in_rob_commit_rd,
    input  logic [DATA_W-1:0] in_rob_commit_value,
    input  logic [ROB_W-1:0]  in_rob_commit_reorder
);

    logic [DATA_W-1:0] r_value [REG_NUM];
    logic [ROB_W-1:0]  r_tag   [REG_NUM];
    logic [REG_NUM-1:0] r_busy;

    logic w_commit;
    logic w_rename;
    logic w_rs_fwd;
    logic w_rt_fwd;

    assign w_commit = in_rob_commit_enable && (in_rob_commit_rd != '0);
    assign w_rename = in_decoder_rename_enable
                   && (in_decoder_rename_rd != '0)
                   && !in_flush_enable;

    // A commit retiring the current producer is forwarded so the
    // decoder never waits an extra cycle for the register-file write.
    assign w_rs_fwd = r_busy[in_decoder_rs]
                   && in_rob_commit_enable
                   && (in_rob_commit_rd == in_decoder_rs)
                   && (in_rob_commit_reorder == r_tag[in_decoder_rs]);
    assign w_rt_fwd = r_busy[in_decoder_rt]
                   && in_rob_commit_enable
                   && (in_rob_commit_rd == in_decoder_rt)
                   && (in_rob_commit_reorder == r_tag[in_decoder_rt]);

    always_comb begin
        out_decoder_rs_busy    = 1'b0;
        out_decoder_rs_reorder = '0;
        out_decoder_rs_value   = '0;
        if (in_decoder_rs == '0) begin
            out_decoder_rs_busy = 1'b0;
        end else if (w_rs_fwd) begin
            out_decoder_rs_value = in_rob_commit_value;
        end else begin
            out_decoder_rs_busy  = r_busy[in_decoder_rs];
            out_decoder_rs_value = r_value[in_decoder_rs];
            if (r_busy[in_decoder_rs]) begin
                out_decoder_rs_reorder = r_tag[in_decoder_rs];
            end
        end
    end

    always_comb begin
        out_decoder_rt_busy    = 1'b0;
        out_decoder_rt_reorder = '0;
        out_decoder_rt_value   = '0;
        if (in_decoder_rt == '0) begin
            out_decoder_rt_busy = 1'b0;
        end else if (w_rt_fwd) begin
            out_decoder_rt_value = in_rob_commit_value;
        end else begin
            out_decoder_rt_busy  = r_busy[in_decoder_rt];
            out_decoder_rt_value = r_value[in_decoder_rt];
            if (r_busy[in_decoder_rt]) begin
                out_decoder_rt_reorder = r_tag[in_decoder_rt];
            end
        end
    end

    // Later assignments win: flush overrides everything on busy/tag,
    // a same-rd rename overrides the commit's busy clear, while the
    // commit value write always lands.
    always_ff @(posedge in_clk) begin
        if (in_rst) begin
            r_busy <= '0;
            for (int i = 0; i < REG_NUM; i++) begin
                r_value[i] <= '0;
                r_tag[i]   <= '0;
            end
        end else if (in_rdy) begin
            if (w_commit) begin
                r_value[in_rob_commit_rd] <= in_rob_commit_value;
                if (r_tag[in_rob_commit_rd] == in_rob_commit_reorder) begin
                    r_busy[in_rob_commit_rd] <= 1'b0;
                    r_tag[in_rob_commit_rd]  <= '0;
                end
            end
            if (in_flush_enable) begin
                r_busy <= '0;
                for (int i = 0; i < REG_NUM; i++) begin
                    r_tag[i] <= '0;
                end
            end else if (w_rename) begin
                r_busy[in_decoder_rename_rd] <= 1'b1;
                r_tag[in_decoder_rename_rd]  <= in_decoder_rename_reorder;
            end
        end
    end

endmodule

// File: tb/tb_reg_rename_file.sv
// tb_reg_rename_file: scoreboard bench for reg_rename_file.
// Expected query results are queued with stimulus and popped at sample.
module tb_reg_rename_file;

    logic        clk = 1'b0;
    logic        rst;
    logic        rdy;
    logic        flush;
    logic [4:0]  rs;
    logic [4:0]  rt;
    logic        rs_busy;
    logic [3:0]  rs_reo;
    logic [31:0] rs_val;
    logic        rt_busy;
    logic [3:0]  rt_reo;
    logic [31:0] rt_val;
    logic        ren_en;
    logic [4:0]  ren_rd;
    logic [3:0]  ren_reo;
    logic        com_en;
    logic [4:0]  com_rd;
    logic [31:0] com_val;
    logic [3:0]  com_reo;

    typedef struct {
        string       name;
        logic        rs_busy;
        logic [3:0]  rs_reo;
        logic [31:0] rs_val;
        logic        rt_busy;
        logic [3:0]  rt_reo;
        logic [31:0] rt_val;
    } exp_t;

    exp_t sb[$];
    int   n_checks = 0;
    int   n_fail   = 0;

    always #5 clk = ~clk;

    reg_rename_file dut (
        .in_clk                    (clk),
        .in_rst                    (rst),
        .in_rdy                    (rdy),
        .in_flush_enable           (flush),
        .in_decoder_rs             (rs),
        .in_decoder_rt             (rt),
        .out_decoder_rs_busy       (rs_busy),
        .out_decoder_rs_reorder    (rs_reo),
        .out_decoder_rs_value      (rs_val),
        .out_decoder_rt_busy       (rt_busy),
        .out_decoder_rt_reorder    (rt_reo),
        .out_decoder_rt_value      (rt_val),
        .in_decoder_rename_enable  (ren_en),
        .in_decoder_rename_rd      (ren_rd),
        .in_decoder_rename_reorder (ren_reo),
        .in_rob_commit_enable      (com_en),
        .in_rob_commit_rd          (com_rd),
        .in_rob_commit_value       (com_val),
        .in_rob_commit_reorder     (com_reo)
    );

    task automatic check_eq(input string tag,
                            input logic [31:0] obs,
                            input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    task automatic expect_q(input string name,
                            input logic b0, input logic [3:0] t0,
                            input logic [31:0] v0,
                            input logic b1, input logic [3:0] t1,
                            input logic [31:0] v1);
        exp_t e;
        e.name = name;
        e.rs_busy = b0; e.rs_reo = t0; e.rs_val = v0;
        e.rt_busy = b1; e.rt_reo = t1; e.rt_val = v1;
        sb.push_back(e);
    endtask

    task automatic sample();
        exp_t e;
        #1;
        if (sb.size() == 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL sb_empty: got 0 entries expected 1");
        end else begin
            e = sb.pop_front();
            check_eq({e.name, ".rs_busy"}, 32'(rs_busy), 32'(e.rs_busy));
            check_eq({e.name, ".rs_reo"},  32'(rs_reo),  32'(e.rs_reo));
            check_eq({e.name, ".rs_val"},  rs_val,       e.rs_val);
            check_eq({e.name, ".rt_busy"}, 32'(rt_busy), 32'(e.rt_busy));
            check_eq({e.name, ".rt_reo"},  32'(rt_reo),  32'(e.rt_reo));
            check_eq({e.name, ".rt_val"},  rt_val,       e.rt_val);
        end
    endtask

    task automatic idle();
        flush  = 1'b0;
        ren_en = 1'b0; ren_rd = '0; ren_reo = '0;
        com_en = 1'b0; com_rd = '0; com_val = '0; com_reo = '0;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic rename(input logic [4:0] rd, input logic [3:0] t);
        ren_en = 1'b1; ren_rd = rd; ren_reo = t;
    endtask

    task automatic commit(input logic [4:0] rd, input logic [3:0] t,
                          input logic [31:0] v);
        com_en = 1'b1; com_rd = rd; com_reo = t; com_val = v;
    endtask

    initial begin
        idle();
        rst = 1'b1; rdy = 1'b1; rs = 5'd5; rt = 5'd0;
        tick(); tick();
        rst = 1'b0;

        expect_q("reset", 0, 0, 0, 0, 0, 0);
        sample();

        rename(5, 3); rs = 5; rt = 5;
        expect_q("ren_same_cyc", 0, 0, 0, 0, 0, 0);
        sample();
        tick(); idle();
        expect_q("x5_busy", 1, 3, 0, 1, 3, 0);
        sample();
        commit(5, 3, 32'h1234);
        expect_q("x5_fwd", 0, 0, 32'h1234, 0, 0, 32'h1234);
        sample();
        tick(); idle();
        expect_q("x5_clean", 0, 0, 32'h1234, 0, 0, 32'h1234);
        sample();

        rename(7, 2); tick();
        rename(7, 6); tick(); idle();
        rs = 7; rt = 0;
        commit(7, 2, 32'hAA);
        expect_q("x7_stale_nofwd", 1, 6, 0, 0, 0, 0);
        sample();
        tick(); idle();
        rs = 0; rt = 7;
        expect_q("x7_stale_state", 0, 0, 0, 1, 6, 32'hAA);
        sample();
        commit(7, 6, 32'hBB);
        expect_q("x7_fwd", 0, 0, 0, 0, 0, 32'hBB);
        sample();
        tick(); idle();
        expect_q("x7_clean", 0, 0, 0, 0, 0, 32'hBB);
        sample();

        rename(9, 4); tick(); idle();
        rs = 9; rt = 9;
        commit(9, 4, 32'h55); rename(9, 8);
        expect_q("x9_fwd", 0, 0, 32'h55, 0, 0, 32'h55);
        sample();
        tick(); idle();
        expect_q("x9_ren_wins", 1, 8, 32'h55, 1, 8, 32'h55);
        sample();

        rename(1, 1); tick();
        rename(2, 2); tick();
        rename(3, 3); tick(); idle();
        rs = 2; rt = 3;
        flush = 1'b1; commit(1, 1, 32'h8000_0004); rename(4, 5);
        expect_q("pre_flush", 1, 2, 0, 1, 3, 0);
        sample();
        tick(); idle();
        rs = 1; rt = 4;
        expect_q("flush_x1_x4", 0, 0, 32'h8000_0004, 0, 0, 0);
        sample();
        rs = 2; rt = 9;
        expect_q("flush_x2_x9", 0, 0, 0, 0, 0, 32'h55);
        sample();

        rdy = 1'b0;
        rename(10, 7); commit(11, 1, 32'hDEAD);
        tick(); idle();
        rdy = 1'b1;
        rs = 10; rt = 11;
        expect_q("rdy_low_hold", 0, 0, 0, 0, 0, 0);
        sample();

        rename(0, 9); commit(0, 9, 32'hFFFF);
        rs = 0; rt = 0;
        expect_q("x0_fwd_block", 0, 0, 0, 0, 0, 0);
        sample();
        tick(); idle();
        expect_q("x0_zero", 0, 0, 0, 0, 0, 0);
        sample();

        rename(12, 3); tick(); idle();
        rs = 12; rt = 5;
        expect_q("x12_busy", 1, 3, 0, 0, 0, 32'h1234);
        sample();
        rst = 1'b1; rdy = 1'b0; rename(13, 2);
        tick(); idle();
        rst = 1'b0; rdy = 1'b1;
        rs = 12; rt = 5;
        expect_q("midrst_a", 0, 0, 0, 0, 0, 0);
        sample();
        rs = 13; rt = 7;
        expect_q("midrst_b", 0, 0, 0, 0, 0, 0);
        sample();

        if (sb.size() != 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL sb_drain: got %0d entries expected 0", sb.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

    initial begin
        #20000;
        $display("FAIL timeout: got no finish expected finish");
        $fatal(1, "timeout");
    end

endmodule
